jtag_tap_ctrl: RTL

//  IEEE 1149.1-style TAP controller that drives the s9234 boundary-scan wrapper.

---
 rtl/jtag_tap_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: 1149.1 TAP controller for the s9234 boundary-scan wrapper.
// Tracks the 16-state TAP FSM, holds the instruction, and steers BSR/ISR/bypass to TDO.
module jtag_tap_ctrl #(
   parameter int unsigned          IR_WIDTH   = 2,
   parameter logic [IR_WIDTH-1:0]  IR_RESET   = 2'b11,
   parameter logic [IR_WIDTH-1:0]  IR_CAPTURE = 2'b01
) (
   input  logic                TCLK,
   input  logic                TRST,
   input  logic                TMS,
   input  logic                TDI,
   input  logic                TDO_BSR,
   input  logic                TDO_ISR,
   output logic                TDO,
   output logic                TDO_EN,
   output logic [IR_WIDTH-1:0] inst,
   output logic                clockdr_bs,
   output logic                shiftdr_bs,
   output logic                updatedr_bs,
   output logic                clockdr_is,
   output logic                shiftdr_is,
   output logic                updatedr_is,
   output logic [3:0]          tap_state
);
   typedef enum logic [3:0] {
      EX2_DR   = 4'h0, EX1_DR   = 4'h1, SH_DR  = 4'h2, PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR = 4'h6, SEL_DR   = 4'h7,
      EX2_IR   = 4'h8, EX1_IR   = 4'h9, SH_IR  = 4'hA, PAUSE_IR = 4'hB,
      RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR = 4'hE, TLR      = 4'hF
   } tap_e;

   localparam logic [IR_WIDTH-1:0] I_EXTEST  = IR_WIDTH'(0);
   localparam logic [IR_WIDTH-1:0] I_SAMPLE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] I_INTSCAN = IR_WIDTH'(2);

   tap_e                state_q, state_d;
   logic [IR_WIDTH-1:0] inst_q, inst_d;
   logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
   logic                byp_q, byp_d;
   logic                tdo_q, tdo_d;
   logic                tdo_en_q, tdo_en_d;
   logic                sel_bsr, sel_isr, sel_byp;

   assign sel_bsr = (inst_q == I_EXTEST) || (inst_q == I_SAMPLE);
   assign sel_isr = (inst_q == I_INTSCAN);
   assign sel_byp = !sel_bsr && !sel_isr;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = TMS ? TLR    : RTI;
         RTI:      state_d = TMS ? SEL_DR : RTI;
         SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
         SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
         EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
         PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
         EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
         UPD_DR:   state_d = TMS ? SEL_DR : RTI;
         SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
         CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
         SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
         EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
         PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
         EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
         UPD_IR:   state_d = TMS ? SEL_DR : RTI;
         default:  state_d = TLR;
      endcase
   end

   // Each IR/DR action happens on the rising edge that ends the cycle spent in its state.
   always_comb begin
      ir_sh_d  = (state_q == CAP_IR) ? IR_CAPTURE :
                 (state_q == SH_IR)  ? {TDI, ir_sh_q[IR_WIDTH-1:1]} : ir_sh_q;
      inst_d   = (state_d == TLR)    ? IR_RESET :
                 (state_q == UPD_IR) ? ir_sh_q : inst_q;
      byp_d    = !sel_byp            ? byp_q :
                 (state_q == CAP_DR) ? 1'b0 :
                 (state_q == SH_DR)  ? TDI : byp_q;
      tdo_d    = (state_q == SH_IR)  ? ir_sh_q[0] :
                 (state_q != SH_DR)  ? 1'b0 :
                 sel_bsr             ? TDO_BSR :
                 sel_isr             ? TDO_ISR : byp_q;
      tdo_en_d = (state_q == SH_IR) || (state_q == SH_DR);
   end

   always_ff @(posedge TCLK or negedge TRST) begin
      if (!TRST) begin
         state_q <= TLR;
         inst_q  <= IR_RESET;
         ir_sh_q <= IR_RESET;
         byp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         ir_sh_q <= ir_sh_d;
         byp_q   <= byp_d;
      end
   end

   always_ff @(negedge TCLK or negedge TRST) begin
      if (!TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign clockdr_bs  = sel_bsr && (state_q == CAP_DR || state_q == SH_DR);
   assign shiftdr_bs  = sel_bsr && (state_q == SH_DR);
   assign updatedr_bs = sel_bsr && (state_q == UPD_DR);
   assign clockdr_is  = sel_isr && (state_q == CAP_DR || state_q == SH_DR);
   assign shiftdr_is  = sel_isr && (state_q == SH_DR);
   assign updatedr_is = sel_isr && (state_q == UPD_DR);
   assign TDO         = tdo_q;
   assign TDO_EN      = tdo_en_q;
   assign inst        = inst_q;
   assign tap_state   = state_q;
endmodule
